adder_share_sched: RTL and testbench

- Round-robin scheduler that time-shares one combinational N_bit_adder between NREQ requesters, such as FFT butterfly address and twiddle-index generators.
- Drives the adder operands from a registered issue stage and captures the sum into a registered response stage.
- Response stage carries a valid/ready handshake tagged with the requester ID.
- Sits between requester logic and the single adder instance inside the FFT top level.

---
 rtl/adder_share_sched_pkg.sv | 25 ++
 rtl/adder_share_sched_if.sv | 30 +++
 rtl/adder_share_sched_rr_arbiter.sv | 36 +++
 rtl/adder_share_sched.sv | 97 +++++++++
 tb/tb_adder_share_sched.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_share_sched_pkg.sv
// Shared defaults and helpers for the adder-sharing scheduler.
package adder_sched_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int NREQ_DEF  = 4;
  // Upper bounds for the operand-slice helper: up to 8 requesters of up to 32 bits.
  localparam int MAX_W     = 32;
  localparam int MAX_N     = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] op_slice(input logic [MAX_N*MAX_W-1:0] vec,
                                                input int unsigned idx,
                                                input int unsigned w);
    logic [MAX_N*MAX_W-1:0] sh;
    sh = vec >> (idx * w);
    return sh[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/adder_share_sched_if.sv
// Requester, shared-adder and response signals of the adder-sharing scheduler.
interface adder_share_sched_if import adder_sched_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
) ();
  localparam int IDW = clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic [WIDTH-1:0]      add_sum;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;

  modport master (
    output req_valid, req_a, req_b, add_sum, rsp_ready,
    input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum
  );

  modport slave (
    input  req_valid, req_a, req_b, add_sum, rsp_ready,
    output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum
  );

endinterface

// File: rtl/adder_share_sched_rr_arbiter.sv
// Rotate-priority pick among NREQ requesters, starting after last_grant.
// ADDER_SCHED_FIXED_PRIO_EN switches to fixed priority (lowest index wins).
module rr_arbiter import adder_sched_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = clog2(NREQ_DEF)
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef ADDER_SCHED_FIXED_PRIO_EN
      cand = IDW'(k);
`else
      cand = IDW'((int'(last_grant) + k + 1) % NREQ);
`endif
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/adder_share_sched.sv
// Time-shares one external combinational adder between NREQ requesters (issue + response stage).
// ADDER_SCHED_FIXED_PRIO_EN selects fixed-priority arbitration instead of round-robin.
module adder_share_sched import adder_sched_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
) (
  input logic               CLK,
  input logic               RST,
  adder_share_sched_if.slave bus
);

  localparam int             IDW      = clog2(NREQ);
  localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

  logic                   vld_p1;
  logic [IDW-1:0]         id_p1;
  logic [WIDTH-1:0]       add_a_p1;
  logic [WIDTH-1:0]       add_b_p1;
  logic                   vld_p2;
  logic [IDW-1:0]         id_p2;
  logic [WIDTH-1:0]       sum_p2;
  logic [IDW-1:0]         last_grant;
  logic                   s2_adv;
  logic                   s1_adv;
  logic                   can_issue;
  logic [NREQ-1:0]        grant;
  logic [IDW-1:0]         gnt_idx;
  logic [MAX_N*MAX_W-1:0] req_a_w;
  logic [MAX_N*MAX_W-1:0] req_b_w;

  assign s2_adv    = !vld_p2 || bus.rsp_ready;
  assign s1_adv    = vld_p1 && s2_adv;
  assign can_issue = !vld_p1 || s2_adv;
  assign req_a_w   = (MAX_N*MAX_W)'(bus.req_a);
  assign req_b_w   = (MAX_N*MAX_W)'(bus.req_b);

  // Grant is suppressed while reset is held so no requester sees a phantom accept.
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req        (bus.req_valid),
    .en         (can_issue && !RST),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (gnt_idx)
  );

`ifdef ADDER_SCHED_FIXED_PRIO_EN
  assign last_grant = LAST_RST;
`else
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_grant <= LAST_RST;
    end else if (can_issue && |grant) begin
      last_grant <= gnt_idx;
    end
  end
`endif

  // Stage 1: issue -- operands of the winner drive the shared adder.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_p1   <= 1'b0;
      id_p1    <= '0;
      add_a_p1 <= '0;
      add_b_p1 <= '0;
    end else if (can_issue) begin
      vld_p1 <= |grant;
      if (|grant) begin
        id_p1    <= gnt_idx;
        add_a_p1 <= WIDTH'(op_slice(req_a_w, 32'(gnt_idx), 32'(WIDTH)));
        add_b_p1 <= WIDTH'(op_slice(req_b_w, 32'(gnt_idx), 32'(WIDTH)));
      end
    end
  end

  // Stage 2: response -- frozen while the consumer withholds rsp_ready.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_p2 <= 1'b0;
      id_p2  <= '0;
      sum_p2 <= '0;
    end else if (s1_adv) begin
      vld_p2 <= 1'b1;
      id_p2  <= id_p1;
      sum_p2 <= bus.add_sum;
    end else if (bus.rsp_ready) begin
      vld_p2 <= 1'b0;
    end
  end

  assign bus.req_ready = grant;
  assign bus.add_a     = add_a_p1;
  assign bus.add_b     = add_b_p1;
  assign bus.rsp_valid = vld_p2;
  assign bus.rsp_id    = id_p2;
  assign bus.rsp_sum   = sum_p2;

endmodule

// File: tb/tb_adder_share_sched.sv
// Bench for adder_share_sched: queue-based in-flight model plus directed literal checks.
module tb_adder_share_sched;

  localparam int W = 8;
  localparam int N = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  adder_share_sched_if #(.WIDTH(W), .NREQ(N)) bus();

  adder_share_sched #(.WIDTH(W), .NREQ(N)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // The shared adder itself: modulo 2^W, carry discarded.
  assign bus.add_sum = bus.add_a + bus.add_b;

  typedef struct {
    int id;
    int a;
    int b;
    int stamp;
  } ent_t;

  ent_t         q[$];
  int           cyc;
  int           last;
  logic [N-1:0] lacc;
  int           total;
  int           bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit bitof(input logic [N-1:0] v, input int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (bitof(v, i)) return i;
    return -1;
  endfunction

  function automatic int opa(input int i);
    return int'((bus.req_a >> (i * W)) & 32'hFF);
  endfunction

  function automatic int opb(input int i);
    return int'((bus.req_b >> (i * W)) & 32'hFF);
  endfunction

  // An operation becomes the visible response once it is the oldest in flight
  // and at least two edges have passed since it was accepted.
  function automatic bit m_rv();
    return q.size() > 0 && cyc >= q[0].stamp + 2;
  endfunction

  function automatic bit m_s1occ();
    return q.size() > (m_rv() ? 1 : 0);
  endfunction

  function automatic logic [N-1:0] m_grant();
    logic [N-1:0] g;
    int j;
    g = '0;
    if (RST) return g;
    if (m_s1occ() && m_rv() && !bus.rsp_ready) return g;
    for (int k = 0; k < N; k++) begin
`ifdef ADDER_SCHED_FIXED_PRIO_EN
      j = k;
`else
      j = (last + 1 + k) % N;
`endif
      if (bitof(bus.req_valid, j)) begin
        g = N'(1) << j;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    q.delete();
    last = N - 1;
    lacc = '0;
  endtask

  task automatic model_update();
    logic [N-1:0] g;
    bit rv;
    int j;
    rv = m_rv();
    g  = m_grant();
    if (rv && bus.rsp_ready) void'(q.pop_front());
    lacc = g;
    if (g != '0) begin
      j = oh_idx(g);
      q.push_back('{j, opa(j), opb(j), cyc});
      last = j;
    end
    cyc++;
  endtask

  task automatic model_check();
    bit rv;
    ent_t e;
    rv = m_rv();
    chk("req_ready", 32'(bus.req_ready), 32'(m_grant()));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(rv));
    if (rv) begin
      chk("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
      chk("rsp_sum", 32'(bus.rsp_sum), 32'((q[0].a + q[0].b) & 'hFF));
    end
    if (m_s1occ()) begin
      e = q[rv ? 1 : 0];
      chk("add_a", 32'(bus.add_a), 32'(e.a));
      chk("add_b", 32'(bus.add_b), 32'(e.b));
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    model_check();
  endtask

  task automatic adv();
    @(posedge CLK);
    if (!RST) model_update();
    #1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_a = (bus.req_a & ~(32'hFF << (i * W))) | ({24'h0, a} << (i * W));
    bus.req_b = (bus.req_b & ~(32'hFF << (i * W))) | ({24'h0, b} << (i * W));
  endtask

  function automatic logic [7:0] rnd_op();
    return ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
  endfunction

  task automatic refresh_accepted();
    for (int i = 0; i < N; i++) if (bitof(lacc, i)) set_ops(i, rnd_op(), rnd_op());
  endtask

  task automatic do_reset();
    RST = 1'b1;
    model_reset();
    #2;
    RST = 1'b0;
  endtask

  task automatic single(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] s);
    set_ops(i, a, b);
    bus.req_valid = N'(1) << i;
    bus.rsp_ready = 1'b1;
    tick();
    chk("single_grant", 32'(bus.req_ready), 32'(N'(1) << i));
    adv();
    bus.req_valid = '0;
    tick();
    chk("single_add_a", 32'(bus.add_a), 32'(a));
    chk("single_add_b", 32'(bus.add_b), 32'(b));
    chk("single_rv_early", 32'(bus.rsp_valid), 32'(0));
    adv();
    tick();
    chk("single_rv", 32'(bus.rsp_valid), 32'(1));
    chk("single_sum", 32'(bus.rsp_sum), 32'(s));
    chk("single_id", 32'(bus.rsp_id), 32'(i));
    adv();
    tick();
    adv();
  endtask

  task automatic drive_random();
    logic [N-1:0] v;
    v = bus.req_valid;
    for (int i = 0; i < N; i++) begin
      if (!(bitof(v, i) && !bitof(lacc, i))) begin
        if ($urandom_range(0, 99) < 55) begin
          v = v | (N'(1) << i);
          set_ops(i, rnd_op(), rnd_op());
        end else begin
          v = v & ~(N'(1) << i);
        end
      end
    end
    bus.req_valid = v;
    bus.rsp_ready = ($urandom_range(0, 99) < 70);
  endtask

  int exp_stream[6];
  int exp_pair[4];

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    model_reset();
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
`ifdef ADDER_SCHED_FIXED_PRIO_EN
    exp_stream = '{0, 0, 0, 0, 0, 0};
    exp_pair   = '{0, 0, 0, 0};
`else
    exp_stream = '{0, 1, 2, 3, 0, 1};
    exp_pair   = '{0, 2, 0, 2};
`endif
    #1 RST = 1'b1;

    // Reset state, with every requester asking.
    tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'(0));
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("rst_add_a", 32'(bus.add_a), 32'(0));
    chk("rst_add_b", 32'(bus.add_b), 32'(0));
    chk("rst_rsp_sum", 32'(bus.rsp_sum), 32'(0));
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'(0));
    #2;
    RST = 1'b0;
    bus.req_valid = '0;
    model_reset();
    adv();

    single(0, 8'h35, 8'h53, 8'h88);
    single(1, 8'hCA, 8'h53, 8'h1D);
    single(3, 8'hFF, 8'h01, 8'h00);

    // Continuous stream from all requesters.
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, rnd_op(), rnd_op());
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k < 6) chk("stream_grant", 32'(bus.req_ready), 32'(N'(1) << exp_stream[k]));
      if (k >= 2) begin
        chk("stream_rv", 32'(bus.rsp_valid), 32'(1));
        chk("stream_id", 32'(bus.rsp_id), 32'(exp_stream[k - 2]));
      end
      adv();
      refresh_accepted();
    end

    // Backpressure for three cycles with both stages full.
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_ready", 32'(bus.req_ready), 32'(0));
      adv();
    end
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      adv();
      refresh_accepted();
    end

    // Two contending requesters.
    do_reset();
    bus.req_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("pair_grant", 32'(bus.req_ready), 32'(N'(1) << exp_pair[k]));
      adv();
      refresh_accepted();
    end

    // Asynchronous reset between edges while responses are flowing.
    bus.req_valid = '1;
    for (int k = 0; k < 3; k++) begin
      tick();
      adv();
      refresh_accepted();
    end
    tick();
    chk("arst_pre_rv", 32'(bus.rsp_valid), 32'(1));
    #1;
    RST = 1'b1;
    bus.req_valid = 4'b0101;
    #1;
    chk("arst_rv", 32'(bus.rsp_valid), 32'(0));
    chk("arst_ready", 32'(bus.req_ready), 32'(0));
    chk("arst_id", 32'(bus.rsp_id), 32'(0));
    model_reset();
    RST = 1'b0;
    #1;
    chk("arst_first", 32'(bus.req_ready), 32'(4'b0001));
    adv();
    for (int k = 0; k < 4; k++) begin
      tick();
      adv();
      refresh_accepted();
    end

    // Randomized traffic with random backpressure.
    for (int k = 0; k < 1500; k++) begin
      drive_random();
      tick();
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
